mem_access_unit: RTL

- Initiator side of the 24-bit data-memory interface.
- Takes single load/store requests from the CPU datapath over a valid/ready handshake.
- Drives the memory's address, write-data, MemWrite and MemRead strobes, captures read data and reports completion with a one-cycle Done pulse.
- Rejects out-of-range addresses without touching memory.

---
 rtl/mem_access_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Initiator side of the 24-bit data-memory interface: single load/store with range check.
// Optional write-verify read-back enabled by defining MAU_WRITE_VERIFY_EN.
module mem_access_unit #(
  parameter int DATA_W       = 24,
  parameter int ADDR_W       = 24,
  parameter int MEM_DEPTH    = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              Req,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqWData,
  output logic              Ready,
  output logic              Done,
  output logic              Err,
  output logic [DATA_W-1:0] RData,
  output logic [ADDR_W-1:0] MemAdresa,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemReadData
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
`ifdef MAU_WRITE_VERIFY_EN
    VFY,
`endif
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH  = ADDR_W'(MEM_DEPTH);
  localparam logic [3:0]        LAT_M1 = 4'(READ_LATENCY - 1);

  state_t state, state_n;
  logic [3:0] cnt;
  logic       err_q;
  logic       accept;
  logic       oor;
  logic       rd_phase;

  assign accept = (state == IDLE) && Req;
  assign oor    = ReqAddr >= DEPTH;

`ifdef MAU_WRITE_VERIFY_EN
  assign rd_phase = (state == RD) || (state == VFY);
`else
  assign rd_phase = (state == RD);
`endif

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (Req) begin
          if (oor)           state_n = DONE;
          else if (ReqWrite) state_n = WR;
          else               state_n = RD;
        end
      end
`ifdef MAU_WRITE_VERIFY_EN
      WR:   state_n = VFY;
      VFY:  if (cnt == 4'd0) state_n = DONE;
`else
      WR:   state_n = DONE;
`endif
      RD:   if (cnt == 4'd0) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      cnt          <= 4'd0;
      err_q        <= 1'b0;
      RData        <= '0;
      MemAdresa    <= '0;
      MemWriteData <= '0;
    end else begin
      if (accept) begin
        MemAdresa    <= ReqAddr;
        MemWriteData <= ReqWData;
        cnt          <= LAT_M1;
        err_q        <= oor;
      end
`ifdef MAU_WRITE_VERIFY_EN
      // read-back window restarts after the write strobe
      if (state == WR) cnt <= LAT_M1;
      if (state == VFY && cnt == 4'd0)
        err_q <= (MemReadData != MemWriteData);
`endif
      if (rd_phase && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == RD && cnt == 4'd0) RData <= MemReadData;
    end
  end

  assign Ready    = (state == IDLE);
  assign Done     = (state == DONE);
  assign Err      = err_q && (state == DONE);
  assign MemWrite = (state == WR);
  assign MemRead  = rd_phase;

endmodule
